// File: rtl/tetris_soc_keycode_fifo_if.sv
// Avalon-MM slave bus plus keycode stream and legacy outputs of the keycode FIFO.
// slave = FIFO side, master = CPU/consumer side.
interface tetris_soc_keycode_fifo_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              key_valid;
    logic [DATA_W-1:0] key_data;
    logic              key_ready;
    logic [DATA_W-1:0] out_port;
    logic              irq;

    modport slave (
        input  address, chipselect, write_n, writedata, key_ready,
        output readdata, key_valid, key_data, out_port, irq
    );

    modport master (
        output address, chipselect, write_n, writedata, key_ready,
        input  readdata, key_valid, key_data, out_port, irq
    );
endinterface

// File: rtl/tetris_soc_keycode_fifo.sv
// Keycode FIFO: CPU pushes keycodes over Avalon-MM, consumer pops them via valid/ready.
// Latency: push visible on key_valid one cycle later; readdata is combinational.
// Backpressure: push into a full FIFO is dropped (sticky ovf) unless a pop frees a slot that cycle.
module tetris_soc_keycode_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    tetris_soc_keycode_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              r_irq_en;
    logic [DATA_W-1:0] r_out_port;

    logic              w_wr;
    logic              w_push;
    logic              w_stat_wr;
    logic              w_ctrl_wr;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_accept;
    logic              w_drop;
    logic              w_flush;
    logic              w_clr_ovf;
    logic [DATA_W-1:0] w_head_dat;

    assign w_wr       = bus.chipselect & ~bus.write_n;
    assign w_push     = w_wr & (bus.address == 2'd0);
    assign w_stat_wr  = w_wr & (bus.address == 2'd1);
    assign w_ctrl_wr  = w_wr & (bus.address == 2'd2);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = ~w_empty & bus.key_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_accept   = w_push & (~w_full | w_pop);
    assign w_drop     = w_push & w_full & ~w_pop;
    assign w_flush    = w_ctrl_wr & bus.writedata[1];
    assign w_clr_ovf  = w_stat_wr & bus.writedata[2];
    assign w_head_dat = r_mem[r_head];

    // Storage carries no reset; entries are only observable while count covers them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_tail] <= bus.writedata[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_irq_en   <= 1'b0;
            r_out_port <= '0;
        end else begin
            if (w_pop) begin
                r_out_port <= w_head_dat;
            end
            if (w_ctrl_wr) begin
                r_irq_en <= bus.writedata[0];
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end
            if (w_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_pop) begin
                    r_head <= r_head + AW'(1);
                end
                if (w_accept) begin
                    r_tail <= r_tail + AW'(1);
                end
                if (w_accept & ~w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (w_pop & ~w_accept) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0: begin
                if (!w_empty) begin
                    bus.readdata[DATA_W-1:0] = w_head_dat;
                end
            end
            2'd1: begin
                bus.readdata[0]      = w_empty;
                bus.readdata[1]      = w_full;
                bus.readdata[2]      = r_ovf;
                bus.readdata[8 +: CW] = r_count;
            end
            2'd2: begin
                bus.readdata[0] = r_irq_en;
            end
            default: begin
                bus.readdata[DATA_W-1:0] = r_out_port;
            end
        endcase
    end

    assign bus.key_valid = ~w_empty;
    assign bus.key_data  = w_head_dat;
    assign bus.out_port  = r_out_port;
    assign bus.irq       = r_irq_en & (r_ovf | ~w_empty);

endmodule

// File: tb/tb_tetris_soc_keycode_fifo.sv
// Directed scenarios plus random traffic against a queue-based reference model of the keycode FIFO.
module tb_tetris_soc_keycode_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    tetris_soc_keycode_fifo_if #(.DATA_W(DW)) bus ();

    tetris_soc_keycode_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] q[$];
    logic          m_ovf;
    logic          m_irq_en;
    logic [DW-1:0] m_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: if (q.size() != 0) r[DW-1:0] = q[0];
            2'd1: begin
                r[0]    = (q.size() == 0);
                r[1]    = (q.size() == DEPTH);
                r[2]    = m_ovf;
                r[15:8] = 8'(q.size());
            end
            2'd2: r[0] = m_irq_en;
            default: r[DW-1:0] = m_out;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf    = 1'b0;
        m_irq_en = 1'b0;
        m_out    = '0;
    endtask

    task automatic model_step(input logic cs, input logic wn, input logic [1:0] a,
                              input logic [31:0] wd, input logic kr);
        logic wr, pop, push, drop;
        wr   = cs && !wn;
        pop  = (q.size() != 0) && kr;
        push = wr && (a == 2'd0);
        drop = push && (q.size() == DEPTH) && !pop;
        if (pop) m_out = q.pop_front();
        if (wr && a == 2'd2 && wd[1]) q.delete();
        if (push && !drop) q.push_back(wd[DW-1:0]);
        if (drop) m_ovf = 1'b1;
        else if (wr && a == 2'd1 && wd[2]) m_ovf = 1'b0;
        if (wr && a == 2'd2) m_irq_en = wd[0];
    endtask

    task automatic check_now(input logic [1:0] a);
        check("key_valid", 32'(bus.key_valid), 32'(q.size() != 0));
        check("irq", 32'(bus.irq), 32'(m_irq_en && (m_ovf || q.size() != 0)));
        check("out_port", 32'(bus.out_port), 32'(m_out));
        if (q.size() != 0) check("key_data", 32'(bus.key_data), 32'(q[0]));
        check("readdata", bus.readdata, exp_rd(a));
    endtask

    // One bus cycle: drive, check combinational outputs, advance model and clock.
    task automatic cyc(input logic cs, input logic wn, input logic [1:0] a,
                       input logic [31:0] wd, input logic kr);
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = wd;
        bus.key_ready  = kr;
        #1;
        check_now(a);
        model_step(cs, wn, a, wd, kr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic kr);
        cyc(1'b1, 1'b0, a, d, kr);
    endtask

    task automatic idle(input logic kr);
        cyc(1'b0, 1'b1, 2'd0, 32'h0, kr);
    endtask

    // Side-effect-free read with no clock edge.
    task automatic peek(input logic [1:0] a);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        bus.writedata  = 32'h0;
        bus.key_ready  = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        reset_n        = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = 32'h0;
        bus.key_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        peek(2'd1);
        check("rst_status", bus.readdata, 32'h0000_0001);
        check("rst_valid", 32'(bus.key_valid), 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        peek(2'd3);
        check("rst_outport", bus.readdata, 32'h0);
        reset_n = 1'b1;

        // Single write appears one cycle later
        wr(2'd0, 32'h1C, 1'b0);
        peek(2'd1);
        check("w1_status", bus.readdata, 32'h0000_0100);
        check("w1_valid", 32'(bus.key_valid), 32'h1);
        check("w1_data", 32'(bus.key_data), 32'h1C);
        idle(1'b1);
        peek(2'd3);
        check("w1_outport", bus.readdata, 32'h1C);

        // Overflow: nine writes into eight entries
        for (int i = 1; i <= 9; i++) wr(2'd0, 32'(i), 1'b0);
        peek(2'd1);
        check("ovf_status", bus.readdata, 32'h0000_0806);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_order", 32'(bus.key_data), 32'(i));
            idle(1'b1);
        end
        peek(2'd3);
        check("ovf_last_out", bus.readdata, 32'h08);
        check("ovf_drained", 32'(bus.key_valid), 32'h0);
        wr(2'd1, 32'h4, 1'b0);
        peek(2'd1);
        check("ovf_cleared", bus.readdata, 32'h0000_0001);

        // Push into full FIFO with simultaneous pop
        for (int i = 0; i < 8; i++) wr(2'd0, 32'h10 + 32'(i), 1'b0);
        wr(2'd0, 32'h2A, 1'b1);
        peek(2'd1);
        check("fullpp_status", bus.readdata, 32'h0000_0802);
        for (int i = 0; i < 7; i++) idle(1'b1);
        check("fullpp_tail", 32'(bus.key_data), 32'h2A);
        idle(1'b1);
        peek(2'd3);
        check("fullpp_out", bus.readdata, 32'h2A);

        // ovf clear with irq enabled
        wr(2'd2, 32'h1, 1'b0);
        for (int i = 0; i < 9; i++) wr(2'd0, 32'h40 + 32'(i), 1'b0);
        wr(2'd2, 32'h3, 1'b0);
        peek(2'd1);
        check("irqovf_status", bus.readdata, 32'h0000_0005);
        check("irqovf_irq", 32'(bus.irq), 32'h1);
        peek(2'd2);
        check("ctrl_read", bus.readdata, 32'h1);
        wr(2'd1, 32'h4, 1'b0);
        peek(2'd1);
        check("irqclr_status", bus.readdata, 32'h0000_0001);
        check("irqclr_irq", 32'(bus.irq), 32'h0);
        for (int i = 0; i < 8; i++) wr(2'd0, 32'h50 + 32'(i), 1'b0);
        wr(2'd0, 32'h55, 1'b0);
        wr(2'd1, 32'h0, 1'b0);
        peek(2'd1);
        check("ovf_kept", bus.readdata, 32'h0000_0806);
        wr(2'd1, 32'h4, 1'b0);
        wr(2'd0, 32'h56, 1'b0);
        peek(2'd1);
        check("ovf_reset_again", bus.readdata, 32'h0000_0806);
        wr(2'd2, 32'h3, 1'b0);
        wr(2'd1, 32'h4, 1'b0);

        // Flush with simultaneous pop
        wr(2'd0, 32'h61, 1'b0);
        wr(2'd0, 32'h62, 1'b0);
        wr(2'd0, 32'h63, 1'b0);
        wr(2'd2, 32'h3, 1'b1);
        peek(2'd3);
        check("flush_out", bus.readdata, 32'h61);
        check("flush_valid", 32'(bus.key_valid), 32'h0);
        peek(2'd1);
        check("flush_status", bus.readdata, 32'h0000_0001);

        // Reset mid-stream with an in-flight push
        for (int i = 0; i < 5; i++) wr(2'd0, 32'h71 + 32'(i), 1'b0);
        check("pre_rst_irq", 32'(bus.irq), 32'h1);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = 2'd0;
        bus.writedata  = 32'h99;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("midrst_valid", 32'(bus.key_valid), 32'h0);
        check("midrst_irq", 32'(bus.irq), 32'h0);
        check("midrst_out", 32'(bus.out_port), 32'h0);
        bus.address = 2'd1;
        #1;
        check("midrst_status", bus.readdata, 32'h0000_0001);
        @(posedge clk);
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        reset_n        = 1'b1;
        wr(2'd0, 32'h33, 1'b0);
        check("postrst_data", 32'(bus.key_data), 32'h33);
        idle(1'b1);
        peek(2'd3);
        check("postrst_out", bus.readdata, 32'h33);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            logic        cs, wn, kr;
            logic [1:0]  a;
            logic [31:0] wd;
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            wd = $urandom;
            if (a == 2'd2 && $urandom_range(0, 7) != 0) wd[1] = 1'b0;
            kr = ($urandom_range(0, 2) == 0);
            cyc(cs, wn, a, wd, kr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
